// File: rtl/button_press_decoder_if.sv
// Button pin in, debounced level and one-cycle event pulses out.
// The decoder holds the master side; downstream consumers hold the slave side.
interface button_press_decoder_if;
    logic WF_BUTTON;
    logic btn_level;
    logic press_pulse;
    logic release_pulse;
    logic short_pulse;
    logic long_pulse;

    modport master (
        input  WF_BUTTON,
        output btn_level, press_pulse, release_pulse, short_pulse, long_pulse
    );

    modport slave (
        output WF_BUTTON,
        input  btn_level, press_pulse, release_pulse, short_pulse, long_pulse
    );
endinterface

// File: rtl/button_press_decoder.sv
// Push-button decoder: 2-flop sync, counter debounce, and a press/hold FSM
// emitting registered single-cycle press, release, short and long pulses.
module button_press_decoder #(
    parameter int unsigned DEBOUNCE_CYCLES = 160000,
    parameter int unsigned LONG_CYCLES     = 16000000,
    parameter bit          ACTIVE_LOW      = 1'b1
) (
    input  logic                   clk,
    input  logic                   reset,
    button_press_decoder_if.master btn
);
    localparam int            DW        = $clog2(DEBOUNCE_CYCLES);
    localparam int            HW        = $clog2(LONG_CYCLES);
    localparam logic          IDLE_PIN  = ACTIVE_LOW;
    localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, HELD, LONG} state_t;

    logic          s1, s2, raw;
    logic [DW-1:0] db_cnt, db_cnt_next;
    logic          level, level_next;
    logic          rise, fall;
    state_t        state, state_next;
    logic [HW-1:0] hold, hold_next;
    logic          press_q, release_q, short_q, long_q;
    logic          press_d, release_d, short_d, long_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1 <= IDLE_PIN;
            s2 <= IDLE_PIN;
        end else begin
            s1 <= btn.WF_BUTTON;
            s2 <= s1;
        end
    end

    assign raw = s2 ^ ACTIVE_LOW;

    // Any sample matching the accepted level restarts the stability count.
    always_comb begin
        db_cnt_next = db_cnt;
        level_next  = level;
        if (raw == level) begin
            db_cnt_next = '0;
        end else if (db_cnt == DB_LAST) begin
            level_next  = ~level;
            db_cnt_next = '0;
        end else begin
            db_cnt_next = db_cnt + DW'(1);
        end
    end

    // Edges are taken from the next level so pulses line up with the toggle.
    assign rise = level_next & ~level;
    assign fall = ~level_next & level;

    always_comb begin
        state_next = state;
        hold_next  = hold;
        press_d    = 1'b0;
        release_d  = 1'b0;
        short_d    = 1'b0;
        long_d     = 1'b0;
        case (state)
            IDLE: begin
                if (rise) begin
                    state_next = HELD;
                    hold_next  = '0;
                    press_d    = 1'b1;
                end
            end
            HELD: begin
                // A release on the threshold edge wins over the long event.
                if (fall) begin
                    state_next = IDLE;
                    release_d  = 1'b1;
                    short_d    = 1'b1;
                end else if (hold == HOLD_LAST) begin
                    state_next = LONG;
                    long_d     = 1'b1;
                end else begin
                    hold_next = hold + HW'(1);
                end
            end
            LONG: begin
                if (fall) begin
                    state_next = IDLE;
                    release_d  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            db_cnt    <= '0;
            level     <= 1'b0;
            state     <= IDLE;
            hold      <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            short_q   <= 1'b0;
            long_q    <= 1'b0;
        end else begin
            db_cnt    <= db_cnt_next;
            level     <= level_next;
            state     <= state_next;
            hold      <= hold_next;
            press_q   <= press_d;
            release_q <= release_d;
            short_q   <= short_d;
            long_q    <= long_d;
        end
    end

    assign btn.btn_level     = level;
    assign btn.press_pulse   = press_q;
    assign btn.release_pulse = release_q;
    assign btn.short_pulse   = short_q;
    assign btn.long_pulse    = long_q;
endmodule

// File: tb/tb_button_press_decoder.sv
// Random pin traces against a window-based reference model; expected pulse
// events are queued and a negedge monitor pops and compares them.
module tb_button_press_decoder;
    localparam int D    = 4;
    localparam int L    = 20;
    localparam bit AL   = 1'b1;
    localparam int NCYC = 4000;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    button_press_decoder_if bus ();

    button_press_decoder #(
        .DEBOUNCE_CYCLES(D),
        .LONG_CYCLES    (L),
        .ACTIVE_LOW     (AL)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .btn  (bus)
    );

    // p = {press, release, short, long}
    typedef struct {
        int         e;
        logic [3:0] p;
    } ev_t;

    ev_t  expq[$];
    bit   rawq[$];
    bit   pin_at [0:NCYC+16];
    int   checks    = 0;
    int   errors    = 0;
    int   edge_n    = 0;
    int   rst_edge  = 0;
    int   press_e   = 0;
    bit   exp_level = 1'b0;
    bit   done      = 1'b0;

    // Pin seen by the debounce at edge e was sampled by s1 two edges earlier,
    // unless a reset since then has refilled the synchronizer with idle.
    task automatic model_step(input int e, input bit r);
        logic [3:0] p = 4'b0;
        bit raw;
        bit all_diff;
        if (r) begin
            exp_level = 1'b0;
            rawq.delete();
            rst_edge = e;
            return;
        end
        raw = (e - 2 > rst_edge) ? (pin_at[e-2] != AL) : 1'b0;
        rawq.push_back(raw);
        if (rawq.size() > D) void'(rawq.pop_front());
        all_diff = (rawq.size() == D);
        foreach (rawq[i]) if (rawq[i] == exp_level) all_diff = 1'b0;
        if (all_diff) begin
            exp_level = !exp_level;
            if (exp_level) begin
                p[3]    = 1'b1;
                press_e = e;
            end else begin
                p[2] = 1'b1;
                p[1] = (e <= press_e + L);
            end
        end else if (exp_level && e == press_e + L) begin
            p[0] = 1'b1;
        end
        if (p != 4'b0) expq.push_back('{e, p});
    endtask

    initial begin
        bit pin      = AL;
        bit rst      = 1'b1;
        int seg_left = 12;
        int rst_left = 0;
        int r;
        bus.WF_BUTTON = AL;
        for (int e = 1; e <= NCYC; e++) begin
            @(negedge clk);
            if (e <= 5) begin
                rst = 1'b1;
            end else if (rst_left > 0) begin
                rst = 1'b1;
                rst_left--;
            end else begin
                rst = 1'b0;
                if ($urandom_range(0, 249) == 0) begin
                    rst      = 1'b1;
                    rst_left = $urandom_range(0, 1);
                end
            end
            if (seg_left == 0) begin
                pin = !pin;
                r   = $urandom_range(0, 9);
                if (r < 3)      seg_left = $urandom_range(1, D - 1);
                else if (r < 7) seg_left = $urandom_range(D, L + D);
                else            seg_left = $urandom_range(L + 1, 3 * L);
            end
            seg_left--;
            bus.WF_BUTTON = pin;
            reset         = rst;
            pin_at[e]     = pin;
            @(posedge clk);
            edge_n = e;
            model_step(e, rst);
        end
        @(negedge clk);
        @(negedge clk);
        done = 1'b1;
        while (expq.size() > 0) begin
            ev_t ev;
            ev = expq.pop_front();
            checks++;
            errors++;
            $display("FAIL unseen_event: edge %0d expected pulses %b, got none", ev.e, ev.p);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    always @(negedge clk) begin : monitor
        logic [3:0] pulses;
        ev_t        ev;
        if (edge_n > 0 && !done) begin
            pulses = {bus.press_pulse, bus.release_pulse, bus.short_pulse, bus.long_pulse};
            checks++;
            if (bus.btn_level !== exp_level) begin
                errors++;
                $display("FAIL btn_level: edge %0d got %b want %b", edge_n, bus.btn_level, exp_level);
            end
            while (expq.size() > 0 && expq[0].e < edge_n) begin
                ev = expq.pop_front();
                checks++;
                errors++;
                $display("FAIL missed_event: edge %0d expected pulses %b, got none", ev.e, ev.p);
            end
            if (expq.size() > 0 && expq[0].e == edge_n) begin
                ev = expq.pop_front();
                checks++;
                if (pulses !== ev.p) begin
                    errors++;
                    $display("FAIL pulses: edge %0d got %b want %b", edge_n, pulses, ev.p);
                end
            end else if (pulses !== 4'b0) begin
                checks++;
                errors++;
                $display("FAIL spurious_pulse: edge %0d got %b want 0000", edge_n, pulses);
            end
        end
    end
endmodule

// File: doc/button_press_decoder.md
Name: button_press_decoder

Overview:
- Input-side counterpart to the LED output path: takes the raw on-board push-button pin (WF_BUTTON) and produces a clean debounced level plus single-cycle event pulses.
- Events are press, release, short-press and long-press.
- Runs in the PLL-derived 16 MHz global clock domain, next to the LED/counter logic in fpga_top.
- Downstream logic (LED mode select, counters) consumes the pulses directly.

Parameters:
- DEBOUNCE_CYCLES, 160000, consecutive stable cycles required to accept a level change (10 ms at 16 MHz); legal range >= 2.
- LONG_CYCLES, 16000000, held cycles after an accepted press that qualify as a long press (1 s at 16 MHz); must be > DEBOUNCE_CYCLES.
- ACTIVE_LOW, 1, 1 = pin reads 0 when pressed (idle high); 0 = pin reads 1 when pressed.

Ports:
- clk  input  1  system clock (PLL global output, 16 MHz)
- reset  input  1  synchronous, active-high reset
- WF_BUTTON  input  1  raw asynchronous button pin
- btn_level  output  1  debounced pressed level (1 = pressed)
- press_pulse  output  1  one-cycle pulse on an accepted press
- release_pulse  output  1  one-cycle pulse on an accepted release
- short_pulse  output  1  one-cycle pulse on release when the long threshold was not reached
- long_pulse  output  1  one-cycle pulse when a press has been held LONG_CYCLES cycles

Behaviour:
- Interface: single clock clk; reset is synchronous and active-high, sampled on posedge clk only.
- Synchronizer: 2-flop chain s1 -> s2 on WF_BUTTON. Reset loads both flops with the idle pin value (1 if ACTIVE_LOW, else 0).
- raw = s2 XOR ACTIVE_LOW, giving 1 = pressed.
- Reset values: btn_level = 0, all pulses = 0, debounce counter = 0, hold counter = 0, FSM = IDLE.
- Debounce counter rules:
  - Width is clog2(DEBOUNCE_CYCLES).
  - When raw == btn_level: counter <= 0.
  - When raw != btn_level and counter == DEBOUNCE_CYCLES-1: btn_level toggles and counter <= 0.
  - Otherwise: counter increments.
- Debounce latency: a clean pin change first sampled by s1 at edge N gives a btn_level toggle at edge N+1+DEBOUNCE_CYCLES.
- Any bounce back to the accepted level before the threshold clears the counter. Glitches shorter than DEBOUNCE_CYCLES are fully rejected.
- FSM states: IDLE, HELD, LONG.
  - IDLE -> HELD on btn_level 0->1: press_pulse = 1 for that one cycle; hold counter <= 0.
  - HELD: hold counter increments each cycle while btn_level = 1.
  - HELD -> LONG when the hold counter reaches LONG_CYCLES-1: long_pulse = 1 for one cycle. long_pulse therefore rises LONG_CYCLES edges after press_pulse.
  - HELD -> IDLE on btn_level 1->0: release_pulse and short_pulse both = 1 in the same cycle.
  - LONG: hold counter frozen (saturates, no wrap).
  - LONG -> IDLE on btn_level 1->0: release_pulse = 1; short_pulse stays 0.
- Pulse properties: all pulses are registered outputs, high for exactly one cycle, and never repeat while held.
- press_pulse coincides with the first cycle btn_level reads 1. release_pulse coincides with the first cycle it reads 0.
- Simultaneous events:
  - Release on the same edge the hold counter hits LONG_CYCLES-1: release wins. Result is IDLE with release_pulse + short_pulse; no long_pulse.
  - Press and release pulses cannot coincide, because the debounce guarantees at least DEBOUNCE_CYCLES between level toggles.
- Reset mid-press: everything returns to reset values on the next edge and no pulse is emitted.
  - After reset, a still-pressed button is re-debounced and produces a fresh press_pulse DEBOUNCE_CYCLES+2 edges later (sync refill plus debounce).
- Hold counter width is clog2(LONG_CYCLES). There is no wrap-around in any counter.

Test Plan (DEBOUNCE_CYCLES=4, LONG_CYCLES=20, ACTIVE_LOW=1, reset deasserted at edge 5):
- Pin driven 0 from edge 10 and held -> btn_level=1 and press_pulse=1 for exactly one cycle after edge 15; long_pulse single cycle after edge 35; no other pulses.
- Pin 0 at edges 10-12, then 1 -> btn_level stays 0; no pulses; debounce counter returns to 0.
- Clean press at edge 10, pin returns to 1 at edge 25 -> release_pulse=1 and short_pulse=1 together after edge 30; no long_pulse.
- Press at edge 10, release at edge 40 -> long_pulse after edge 35; release_pulse after edge 45 with short_pulse=0.
- Bounce pattern 0,1,0,1,0 (one cycle each) then steady 0 from edge 20 -> exactly one press_pulse, after edge 25.
- Press held, reset asserted for 1 cycle at edge 30 -> all outputs 0 after edge 30; press_pulse reasserts after edge 36 while the pin stays 0.
